galois_inv_fermat: RTL and testbench



---
 rtl/galois_pkg.sv | 35 +++
 rtl/galois_mult_barrett.sv | 92 +++++++++
 rtl/galois_inv_fermat.sv | 122 ++++++++++++
 tb/tb_galois_inv_fermat.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/galois_pkg.sv
// rtl/galois_pkg.sv - shared constants and state encodings for the Galois field blocks
//
// Holds the BN254 scalar-field constants, the inverter and multiplier state
// encodings, and the fixed per-operation latency of the multiplier as seen
// by the inverter (RST, EN, three compute cycles, FINISH, capture).
package galois_pkg;

  localparam logic [253:0] BN254_P =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [254:0] BN254_R =
    255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925;
  localparam logic [253:0] BN254_P_MINUS_2 =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593efffffff;

  localparam int MULT_OP_CYCLES = 7;

  // Inverter states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SQ_RST   = 3'd1;
  localparam logic [2:0] ST_SQ_EN    = 3'd2;
  localparam logic [2:0] ST_SQ_WAIT  = 3'd3;
  localparam logic [2:0] ST_MUL_RST  = 3'd4;
  localparam logic [2:0] ST_MUL_EN   = 3'd5;
  localparam logic [2:0] ST_MUL_WAIT = 3'd6;
  localparam logic [2:0] ST_FIN      = 3'd7;

  // Multiplier states
  localparam logic [2:0] MS_INIT      = 3'd0;
  localparam logic [2:0] MS_COMPUTE_1 = 3'd1;
  localparam logic [2:0] MS_COMPUTE_2 = 3'd2;
  localparam logic [2:0] MS_COMPUTE_3 = 3'd3;
  localparam logic [2:0] MS_FINISH    = 3'd4;
  localparam logic [2:0] MS_DONE      = 3'd5;

endpackage

// File: rtl/galois_mult_barrett.sv
// rtl/galois_mult_barrett.sv - Barrett modular multiplier with sticky en/done handshake
//
// Ports:
//   clk, rst    clock and synchronous active-high reset (only way back to INIT)
//   en          start request, taken in INIT; operands latched on that edge
//   a, b        operands, each < PRIME_MODULUS
//   product     a*b mod PRIME_MODULUS, valid while done is high
//   done        high from the end of FINISH until the next reset
module galois_mult_barrett
  import galois_pkg::*;
#(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_P,
  parameter logic [N_BITS:0]   R             = BN254_R
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] product,
  output logic              done
);

  localparam int W2 = 2 * N_BITS;
  localparam int WR = N_BITS + 2;

  logic [2:0]        state, state_nx;
  logic [N_BITS-1:0] op_a, op_b;
  logic [W2-1:0]     x;
  logic [N_BITS:0]   q;
  logic [WR-1:0]     r;
  logic [WR-1:0]     r_nx;
  logic [WR-1:0]     p1, p2;

  assign p1 = WR'(PRIME_MODULUS);
  assign p2 = WR'(PRIME_MODULUS) << 1;

  // The true remainder is below 3p < 2^WR, so arithmetic modulo 2^WR is exact.
  assign r_nx = x[WR-1:0] - WR'(WR'(q) * p1);

  always_ff @(posedge clk) begin
    if (rst) state <= MS_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MS_INIT:      if (en) state_nx = MS_COMPUTE_1;
      MS_COMPUTE_1: state_nx = MS_COMPUTE_2;
      MS_COMPUTE_2: state_nx = MS_COMPUTE_3;
      MS_COMPUTE_3: state_nx = MS_FINISH;
      MS_FINISH:    state_nx = MS_DONE;
      MS_DONE:      state_nx = MS_DONE;
      default:      state_nx = MS_INIT;
    endcase
  end

  always_comb begin
    done = (state == MS_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      x       <= '0;
      q       <= '0;
      r       <= '0;
      product <= '0;
    end else begin
      case (state)
        MS_INIT: if (en) begin
          op_a <= a;
          op_b <= b;
        end
        MS_COMPUTE_1: x <= W2'(op_a) * W2'(op_b);
        // Quotient estimate: floor(floor(x / 2^(N-1)) * R / 2^(N+1)), short by at most 2.
        MS_COMPUTE_2: q <= (N_BITS+1)'(((W2+2)'(x[W2-1:N_BITS-1]) * (W2+2)'(R)) >> (N_BITS+1));
        MS_COMPUTE_3: r <= r_nx;
        MS_FINISH: begin
          if (r >= p2)      product <= N_BITS'(r - p2);
          else if (r >= p1) product <= N_BITS'(r - p1);
          else              product <= N_BITS'(r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/galois_inv_fermat.sv
// rtl/galois_inv_fermat.sv - field inverse a^(p-2) mod p by left-to-right square-and-multiply
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     request pulse, accepted only in IDLE
//   a         operand (< p), sampled on the accepting edge
//   result    a^-1 mod p, held from done until the next accepted start
//   busy      high from the cycle after acceptance until done
//   done      one-cycle pulse when result is valid
module galois_inv_fermat
  import galois_pkg::*;
#(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_P,
  parameter logic [N_BITS:0]   R             = BN254_R,
  parameter logic [N_BITS-1:0] EXPONENT      = BN254_P_MINUS_2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  output logic [N_BITS-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(N_BITS);

  logic [2:0]        state, state_nx;
  logic [N_BITS-1:0] acc, base;
  logic [BIT_W-1:0]  bit_idx;
  logic              exp_bit, last_bit;

  logic              mult_rst, mult_en, mult_done;
  logic [N_BITS-1:0] mult_a, mult_b, mult_product;

  assign exp_bit  = EXPONENT[bit_idx];
  assign last_bit = (bit_idx == '0);

  galois_mult_barrett #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .R             (R)
  ) u_mult (
    .clk     (clk),
    .rst     (mult_rst),
    .en      (mult_en),
    .a       (mult_a),
    .b       (mult_b),
    .product (mult_product),
    .done    (mult_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_SQ_RST;
      ST_SQ_RST:   state_nx = ST_SQ_EN;
      ST_SQ_EN:    state_nx = ST_SQ_WAIT;
      ST_SQ_WAIT:
        if (mult_done) begin
          if (exp_bit)       state_nx = ST_MUL_RST;
          else if (last_bit) state_nx = ST_FIN;
          else               state_nx = ST_SQ_RST;
        end
      ST_MUL_RST:  state_nx = ST_MUL_EN;
      ST_MUL_EN:   state_nx = ST_MUL_WAIT;
      ST_MUL_WAIT:
        if (mult_done) state_nx = last_bit ? ST_FIN : ST_SQ_RST;
      ST_FIN:      state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // The multiplier's done is sticky, so it is reset ahead of every operation;
  // operands stay fixed from *_RST through *_WAIT because acc only changes on capture.
  always_comb begin
    mult_rst = rst | (state == ST_SQ_RST) | (state == ST_MUL_RST);
    mult_en  = (state == ST_SQ_EN) | (state == ST_MUL_EN);
    mult_a   = acc;
    mult_b   = ((state == ST_MUL_RST) | (state == ST_MUL_EN) | (state == ST_MUL_WAIT)) ? base : acc;
    busy     = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      base    <= '0;
      bit_idx <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          base    <= a;
          acc     <= N_BITS'(1);
          bit_idx <= BIT_W'(N_BITS - 1);
        end
        ST_SQ_WAIT: if (mult_done) begin
          acc <= mult_product;
          if (!exp_bit && !last_bit) bit_idx <= bit_idx - 1'b1;
        end
        ST_MUL_WAIT: if (mult_done) begin
          acc <= mult_product;
          if (!last_bit) bit_idx <= bit_idx - 1'b1;
        end
        ST_FIN: begin
          result <= acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_galois_inv_fermat.sv
// tb/tb_galois_inv_fermat.sv - directed bench for galois_inv_fermat (BN254 and GF(251) configs)
module tb_galois_inv_fermat;

  localparam logic [253:0] P_BIG   =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [253:0] E_BIG   =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593efffffff;
  localparam logic [253:0] INV2_BIG =
    254'h183227397098d014dc2822db40c0ac2e9419f4243cdcb848a1f0fac9f8000001;
  localparam int LAT_BIG   = 7 * (254 + $countones(E_BIG)) + 1;
  localparam int LAT_SMALL = 99;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         b_rst, b_start, b_busy, b_done;
  logic [253:0] b_a, b_res;
  logic         s_rst, s_start, s_busy, s_done;
  logic [7:0]   s_a, s_res;

  int checks = 0;
  int errors = 0;

  galois_inv_fermat u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .a(b_a),
    .result(b_res), .busy(b_busy), .done(b_done)
  );

  galois_inv_fermat #(
    .N_BITS(8), .PRIME_MODULUS(8'd251), .R(9'h105), .EXPONENT(8'd249)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .a(s_a),
    .result(s_res), .busy(s_busy), .done(s_done)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns latency in cycles from accepting edge to done.
  task automatic inv_small(input logic [7:0] av, input bit spam,
                           output logic [7:0] res, output int lat, output int busy_bad);
    s_a = av;
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
      if (s_done) break;
      if (!s_busy) busy_bad++;
      if (spam) begin
        s_start = (lat % 7 == 0);
        s_a = 8'(lat);
      end
    end
    s_start = 1'b0;
    s_a = av;
    res = s_res;
    if (!s_done) check("small_timeout", 256'(lat), 256'(LAT_SMALL));
  endtask

  task automatic inv_big(input logic [253:0] av, output logic [253:0] res,
                         output int lat, output int busy_bad);
    b_a = av;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (lat < 20000) begin
      @(posedge clk);
      lat++;
      #1;
      if (b_done) break;
      if (!b_busy) busy_bad++;
    end
    res = b_res;
    if (!b_done) check("big_timeout", 256'(lat), 256'(LAT_BIG));
  endtask

  logic [7:0]   sr;
  logic [253:0] br;
  int           lat, bb, nd;

  initial begin
    b_rst = 1'b1; b_start = 1'b0; b_a = '0;
    s_rst = 1'b1; s_start = 1'b0; s_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_big_result", 256'(b_res), 256'd0);
    check("rst_big_busy",   256'(b_busy), 256'd0);
    check("rst_big_done",   256'(b_done), 256'd0);
    check("rst_small_result", 256'(s_res), 256'd0);
    check("rst_small_busy",   256'(s_busy), 256'd0);
    b_rst = 1'b0;
    s_rst = 1'b0;
    @(posedge clk);
    #1;

    // BN254: a=1, a=2, a=0
    inv_big(254'd1, br, lat, bb);
    check("big_a1_result", 256'(br), 256'd1);
    check("big_a1_latency", 256'(lat), 256'(LAT_BIG));
    check("big_a1_busy", 256'(bb), 256'd0);
    check("big_a1_busy_at_done", 256'(b_busy), 256'd0);
    @(posedge clk);
    #1 check("big_done_pulse", 256'(b_done), 256'd0);
    inv_big(254'd2, br, lat, bb);
    check("big_a2_result", 256'(br), 256'(INV2_BIG));
    check("big_a2_is_half", 256'((256'(P_BIG) + 256'd1) >> 1), 256'(INV2_BIG));
    inv_big(254'd0, br, lat, bb);
    check("big_a0_result", 256'(br), 256'd0);
    check("big_a0_latency", 256'(lat), 256'(LAT_BIG));

    // GF(251): known vectors, then full sweep
    inv_small(8'd3, 1'b0, sr, lat, bb);
    check("small_a3_result", 256'(sr), 256'd84);
    check("small_a3_latency", 256'(lat), 256'(LAT_SMALL));
    check("small_a3_busy", 256'(bb), 256'd0);
    inv_small(8'd0, 1'b0, sr, lat, bb);
    check("small_a0_result", 256'(sr), 256'd0);
    check("small_a0_latency", 256'(lat), 256'(LAT_SMALL));
    for (int i = 1; i <= 250; i++) begin
      inv_small(8'(i), 1'b0, sr, lat, bb);
      check($sformatf("small_sweep_a%0d", i), 256'((i * int'(sr)) % 251), 256'd1);
      check($sformatf("small_sweep_lat%0d", i), 256'(lat), 256'(LAT_SMALL));
    end

    // Reset halfway through, with start asserted alongside rst
    s_a = 8'd5; s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    nd = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (s_done) nd++;
    end
    s_rst = 1'b1; s_start = 1'b1; s_a = 8'd9;
    @(posedge clk);
    #1;
    check("abort_busy", 256'(s_busy), 256'd0);
    check("abort_done", 256'(s_done), 256'd0);
    check("abort_result", 256'(s_res), 256'd0);
    s_rst = 1'b0; s_start = 1'b0;
    repeat (120) begin
      @(posedge clk);
      #1 if (s_done || s_busy) nd++;
    end
    check("abort_no_done", 256'(nd), 256'd0);
    inv_small(8'd2, 1'b0, sr, lat, bb);
    check("after_abort_result", 256'(sr), 256'd126);
    check("after_abort_latency", 256'(lat), 256'(LAT_SMALL));

    // start pulses while busy (including in FIN) are ignored
    inv_small(8'd7, 1'b1, sr, lat, bb);
    check("spam_result", 256'(sr), 256'd36);
    check("spam_latency", 256'(lat), 256'(LAT_SMALL));
    check("spam_busy", 256'(bb), 256'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (s_done || s_busy) nd++;
    end
    check("spam_single_done", 256'(nd), 256'd0);
    check("spam_result_hold", 256'(s_res), 256'd36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
